regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised successor to the single-port MIPS register file: a DEPTH x WIDTH register array with two combinational read ports, a primary write port, an auxiliary write port for the divider's remainder/quotient result, and a per-register pending scoreboard. Writes are clock-synchronous with optional same-cycle write-to-read bypass. Register 0 is optionally hardwired to zero. The block sits in the decode stage of the 4-stage pipeline: ALU/memory write-back uses the primary write port and the multicycle divider uses the auxiliary port.

## Interface
- WIDTH, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and reservations
- BYPASS, 1, when 1, reads return same-cycle write data

- Clk  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ReadRegister1, ReadRegister2  in  ADDR_W  read addresses
- ReadData1, ReadData2  out  WIDTH  read data, combinational
- RegWrite  in  1  primary write enable
- WriteRegister  in  ADDR_W  primary write address
- WriteData  in  WIDTH  primary write data
- AuxWrite  in  1  auxiliary (divider) write enable
- AuxRegister  in  ADDR_W  auxiliary write address
- AuxData  in  WIDTH  auxiliary write data
- Reserve  in  1  mark ReserveRegister pending (divider issue)
- ReserveRegister  in  ADDR_W  register to reserve
- Busy1, Busy2  out  1  read register 1/2 has an outstanding reservation
- Pending  out  DEPTH  full scoreboard vector, bit i = register i pending

## Operation
- Storage: DEPTH registers of WIDTH bits and a DEPTH-bit pending vector, all flops.
- Reset (Reset_n low, asynchronous): all registers = 0, Pending = 0. Outputs: ReadData* = 0, Busy* = 0, Pending = 0. Held while Reset_n is low; the first write is accepted on the first rising edge after release.
- Primary write: RegWrite=1 writes WriteData into WriteRegister at the rising edge.
- Aux write: AuxWrite=1 writes AuxData into AuxRegister at the same edge and clears Pending[AuxRegister].
- Same address on both writes in one cycle: aux data is stored (aux has priority). The primary write is dropped.
- Primary writes never modify Pending.
- Reserve=1 sets Pending[ReserveRegister] at the edge. Reserving an already-pending register leaves it set.
- Reserve and aux write to the same register in one cycle: the register takes AuxData and Pending stays 1 (the new reservation wins).
- ZERO_REG=1: address 0 reads 0, writes to address 0 are discarded, reservations of address 0 are ignored, Pending[0] is constantly 0.
- Read path, per port N:
  - BYPASS=1 and AuxWrite and AuxRegister==ReadRegisterN: return AuxData.
  - Otherwise, BYPASS=1 and RegWrite and WriteRegister==ReadRegisterN: return WriteData.
  - Otherwise: return the stored value.
  - Bypass never applies to address 0 when ZERO_REG=1.
- BusyN = Pending[ReadRegisterN], except when BYPASS=1 and an aux write to that address occurs this cycle without a same-cycle Reserve of it. In that case BusyN = 0.
- Both read ports are fully independent. Reading the same address on both ports is legal.

## Timing
- Read latency 0: combinational from address, stored state and (if BYPASS) write-port inputs.
- Write latency 1 edge. With BYPASS=0, a written value is visible from the cycle after the edge.
- Pending set/clear takes effect at the edge. Pending output is registered (no combinational path from inputs).
- Reset assertion mid-cycle clears state immediately, with no clock required. Any write coincident with reset is lost.
- No back-pressure. Every enable is accepted in the cycle it is asserted.

## Test plan
- Reset: preload R5=0x1234, assert Reset_n=0 between edges -> ReadData1 (addr 5)=0 and Pending=0 immediately, with no clock edge.
- Write/read, bypass: RegWrite, WriteRegister=7, WriteData=0xDEADBEEF, ReadRegister1=7:
  - BYPASS=1 -> ReadData1=0xDEADBEEF in the same cycle.
  - BYPASS=0 -> ReadData1=0 in that cycle and 0xDEADBEEF in the next cycle.
- Zero register: RegWrite to addr 0 with 0xFFFFFFFF, plus Reserve addr 0 -> ReadData1(addr 0)=0, Busy1=0, Pending[0]=0.
- Port conflict: RegWrite R30=0x11 and AuxWrite R30=0x22 in the same cycle -> R30 reads 0x22 next cycle, and the bypass read returns 0x22 in the same cycle.
- Scoreboard: Reserve R29 -> next cycle Busy2(addr 29)=1 and Pending[29]=1. Primary write to R29 -> still busy. AuxWrite R29=0x5 -> Busy2=0 in that cycle (BYPASS=1) and Pending[29]=0 next cycle.
- Simultaneous reserve and clear: Reserve R29 and AuxWrite R29=0x9 in one cycle -> R29=0x9 and Pending[29]=1 after the edge.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport: dual-read register file with primary/aux write ports and a pending scoreboard
module regfile_multiport #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              AuxWrite,
  input  logic [ADDR_W-1:0] AuxRegister,
  input  logic [WIDTH-1:0]  AuxData,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveRegister,
  output logic              Busy1,
  output logic              Busy2,
  output logic [DEPTH-1:0]  Pending
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic             wr_ok, aux_ok, res_ok;
  logic             zero1, zero2, aux1, aux2, pri1, pri2, res1, res2;
  // Address 0 swallows writes and reservations when it is hardwired to zero
  always_comb begin
    wr_ok  = RegWrite && !(ZERO_REG != 0 && WriteRegister == '0);
    aux_ok = AuxWrite && !(ZERO_REG != 0 && AuxRegister == '0);
    res_ok = Reserve && !(ZERO_REG != 0 && ReserveRegister == '0);
  end
  // Register array: aux write is issued last so it overrides a same-address primary write
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_ok) regs[WriteRegister] <= WriteData;
      if (aux_ok) regs[AuxRegister] <= AuxData;
    end
  // Scoreboard: aux write retires a reservation, a same-cycle new reservation wins
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      pend <= '0;
    end else begin
      if (aux_ok) pend[AuxRegister] <= 1'b0;
      if (res_ok) pend[ReserveRegister] <= 1'b1;
    end
  assign Pending = pend;
  // Per-port address match decode for zero register, bypass sources and same-cycle reserve
  always_comb begin
    zero1 = ZERO_REG != 0 && ReadRegister1 == '0;
    zero2 = ZERO_REG != 0 && ReadRegister2 == '0;
    aux1  = BYPASS != 0 && AuxWrite && AuxRegister == ReadRegister1;
    aux2  = BYPASS != 0 && AuxWrite && AuxRegister == ReadRegister2;
    pri1  = BYPASS != 0 && RegWrite && WriteRegister == ReadRegister1;
    pri2  = BYPASS != 0 && RegWrite && WriteRegister == ReadRegister2;
    res1  = Reserve && ReserveRegister == ReadRegister1;
    res2  = Reserve && ReserveRegister == ReadRegister2;
  end
  // Read mux: reset forces zero, aux bypass beats primary bypass beats stored value
  always_comb begin
    ReadData1 = (!Reset_n || zero1) ? '0 : aux1 ? AuxData : pri1 ? WriteData : regs[ReadRegister1];
    ReadData2 = (!Reset_n || zero2) ? '0 : aux2 ? AuxData : pri2 ? WriteData : regs[ReadRegister2];
  end
  // Busy hides a reservation being retired by this cycle's aux write unless it is re-reserved
  always_comb begin
    Busy1 = pend[ReadRegister1] && !(aux1 && !res1);
    Busy2 = pend[ReadRegister2] && !(aux2 && !res2);
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: randomized check of bypass and non-bypass register files against a reference model
module tb_regfile_multiport;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [4:0]  rr1, rr2, wr, ar, resr;
  logic [31:0] wd, ad;
  logic        rw, aw, rs;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n, pend_b, pend_n;
  logic        b1_b, b2_b, b1_n, b2_n;
  logic [31:0] mregs [32];
  bit          mpend [32];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 Clk = ~Clk;

  regfile_multiport #(.BYPASS(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .RegWrite(rw), .WriteRegister(wr), .WriteData(wd),
    .AuxWrite(aw), .AuxRegister(ar), .AuxData(ad), .Reserve(rs), .ReserveRegister(resr),
    .Busy1(b1_b), .Busy2(b2_b), .Pending(pend_b));

  regfile_multiport #(.BYPASS(0)) dut_nb (
    .Clk(Clk), .Reset_n(Reset_n), .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1_n), .ReadData2(rd2_n), .RegWrite(rw), .WriteRegister(wr), .WriteData(wd),
    .AuxWrite(aw), .AuxRegister(ar), .AuxData(ad), .Reserve(rs), .ReserveRegister(resr),
    .Busy1(b1_n), .Busy2(b2_n), .Pending(pend_n));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!Reset_n || a == 0) return 32'h0;
    if (byp && aw && ar == a) return ad;
    if (byp && rw && wr == a) return wd;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    return mpend[a] && !(byp && aw && ar == a && !(rs && resr == a));
  endfunction

  function automatic logic [31:0] exp_pend();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = mpend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 32'h0;
      mpend[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rw && wr != 0) mregs[wr] = wd;
    if (aw && ar != 0) mregs[ar] = ad;
    if (aw) mpend[ar] = 1'b0;
    if (rs && resr != 0) mpend[resr] = 1'b1;
  endtask

  task automatic compare_all();
    check("rd1_byp", rd1_b, exp_rd(rr1, 1));
    check("rd2_byp", rd2_b, exp_rd(rr2, 1));
    check("rd1_nobyp", rd1_n, exp_rd(rr1, 0));
    check("rd2_nobyp", rd2_n, exp_rd(rr2, 0));
    check("busy1_byp", 32'(b1_b), 32'(exp_busy(rr1, 1)));
    check("busy2_byp", 32'(b2_b), 32'(exp_busy(rr2, 1)));
    check("busy1_nobyp", 32'(b1_n), 32'(exp_busy(rr1, 0)));
    check("busy2_nobyp", 32'(b2_n), 32'(exp_busy(rr2, 0)));
    check("pend_byp", pend_b, exp_pend());
    check("pend_nobyp", pend_n, exp_pend());
  endtask

  task automatic drive(input logic r_w, input logic [4:0] w_r, input logic [31:0] w_d,
                       input logic a_w, input logic [4:0] a_r, input logic [31:0] a_d,
                       input logic r_s, input logic [4:0] r_r, input logic [4:0] r1, input logic [4:0] r2);
    rw = r_w; wr = w_r; wd = w_d; aw = a_w; ar = a_r; ad = a_d; rs = r_s; resr = r_r; rr1 = r1; rr2 = r2;
  endtask

  task automatic tick();
    #2;
    compare_all();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  function automatic logic [4:0] raddr();
    return $urandom_range(0, 1) != 0 ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    Reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    // asynchronous reset with a preloaded register
    drive(1, 5, 32'h1234, 0, 0, 0, 1, 5, 5, 5);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    #1;
    check("preload_r5", rd1_n, 32'h1234);
    Reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_rd", rd1_b, 32'h0);
    check("async_rst_pend", pend_b, 32'h0);
    compare_all();
    Reset_n = 1'b1;
    tick();
    // write with same-cycle bypass
    drive(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 7, 7);
    #1;
    check("byp_same_cycle", rd1_b, 32'hDEADBEEF);
    check("nobyp_same_cycle", rd1_n, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    #1;
    check("nobyp_next_cycle", rd1_n, 32'hDEADBEEF);
    tick();
    // zero register ignores writes and reservations
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("zero_rd", rd1_b, 32'h0);
    check("zero_busy", 32'(b1_b), 32'h0);
    check("zero_pend0", 32'(pend_b[0]), 32'h0);
    tick();
    // write port conflict: aux wins
    drive(1, 30, 32'h11, 1, 30, 32'h22, 0, 0, 30, 30);
    #1;
    check("conflict_byp", rd1_b, 32'h22);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 30, 30);
    #1;
    check("conflict_stored", rd1_n, 32'h22);
    tick();
    // scoreboard lifecycle
    drive(0, 0, 0, 0, 0, 0, 1, 29, 0, 29);
    tick();
    drive(1, 29, 32'h77, 0, 0, 0, 0, 0, 0, 29);
    #1;
    check("reserve_busy", 32'(b2_b), 32'h1);
    check("reserve_pend", 32'(pend_b[29]), 32'h1);
    tick();
    drive(0, 0, 0, 1, 29, 32'h5, 0, 0, 0, 29);
    #1;
    check("prim_still_busy", 32'(b2_n), 32'h1);
    check("aux_clear_busy_byp", 32'(b2_b), 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 29);
    #1;
    check("aux_clear_pend", 32'(pend_b[29]), 32'h0);
    check("aux_data", rd2_n, 32'h5);
    tick();
    // simultaneous reserve and aux clear
    drive(0, 0, 0, 1, 29, 32'h9, 1, 29, 29, 29);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 29, 29);
    #1;
    check("res_aux_data", rd1_n, 32'h9);
    check("res_aux_pend", 32'(pend_n[29]), 32'h1);
    tick();
    // randomized traffic with occasional mid-cycle reset
    for (int n = 0; n < 1500; n++) begin
      drive(1'($urandom_range(0, 1)), raddr(), $urandom(), 1'($urandom_range(0, 1)), raddr(), $urandom(),
            1'($urandom_range(0, 2) == 0), raddr(), raddr(), raddr());
      if ($urandom_range(0, 99) == 0) begin
        Reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        Reset_n = 1'b1;
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
